// File: rtl/write_vrf_multi_if.sv
// write_vrf_multi_if: per-lane DFX FIFO read ports plus the merged VRF write port
interface write_vrf_multi_if #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_CH = 4,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  localparam int DFX_W = DATA_WIDTH + ADDR_WIDTH;
  logic [NUM_CH-1:0] empty_dfx_fifo;
  logic [NUM_CH*DFX_W-1:0] data_dfx_recv;
  logic [NUM_CH-1:0] read_dfx_fifo;
  logic write_gnt;
  logic write_req;
  logic [ADDR_WIDTH-1:0] vrf_dst_addr;
  logic [DATA_WIDTH-1:0] data_recv;
  logic [CH_W-1:0] write_ch;
  modport master (
    input empty_dfx_fifo, data_dfx_recv, write_gnt,
    output read_dfx_fifo, write_req, vrf_dst_addr, data_recv, write_ch
  );
  modport slave (
    output empty_dfx_fifo, data_dfx_recv, write_gnt,
    input read_dfx_fifo, write_req, vrf_dst_addr, data_recv, write_ch
  );
endinterface

// File: rtl/write_vrf_multi.sv
// write_vrf_multi: merges NUM_CH DFX FIFOs into one registered VRF write port; WR_STALL_CNT_EN adds stall_cnt
module write_vrf_multi #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_CH = 4,
  parameter int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
`ifdef WR_STALL_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input logic clk,
  input logic rst,
  write_vrf_multi_if.master bus
`ifdef WR_STALL_CNT_EN
  , output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} st_e;
  st_e st [NUM_CH];
  st_e st_n [NUM_CH];
  logic [ADDR_WIDTH-1:0] slot_addr [NUM_CH];
  logic [DATA_WIDTH-1:0] slot_data [NUM_CH];
  logic [NUM_CH-1:0] hold;
  logic [NUM_CH-1:0] avail;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] cand;
  int idx;
  logic found;
  logic free;
  logic launch;
  assign avail = ~bus.empty_dfx_fifo & {NUM_CH{!rst}};
  assign free = !bus.write_req || bus.write_gnt;
  assign launch = free && found;
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) hold[c] = st[c] == HOLD;
  end
  // round-robin search starting one past the last launched channel
  always_comb begin
    sel = ptr;
    found = 1'b0;
    idx = 0;
    cand = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(ptr) + k;
      idx = idx >= NUM_CH ? idx - NUM_CH : idx;
      cand = CH_W'(idx);
      if (!found && hold[cand]) begin
        sel = cand;
        found = 1'b1;
      end
    end
  end
  // a HOLD channel may only re-pop in the cycle its slot is launched
  always_comb begin
    bus.read_dfx_fifo = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      st_n[c] = st[c];
      if (st[c] == IDLE && avail[c]) begin
        bus.read_dfx_fifo[c] = 1'b1;
        st_n[c] = FETCH;
      end else if (st[c] == FETCH) begin
        st_n[c] = HOLD;
      end else if (st[c] == HOLD && launch && sel == CH_W'(c)) begin
        bus.read_dfx_fifo[c] = avail[c];
        st_n[c] = avail[c] ? FETCH : IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) st[c] <= rst ? IDLE : st_n[c];
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (st[c] == FETCH) begin
        slot_addr[c] <= bus.data_dfx_recv[c*DATA_DFX_WIDTH +: ADDR_WIDTH];
        slot_data[c] <= bus.data_dfx_recv[c*DATA_DFX_WIDTH+ADDR_WIDTH +: DATA_WIDTH];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.write_req <= 1'b0;
      bus.vrf_dst_addr <= '0;
      bus.data_recv <= '0;
      bus.write_ch <= '0;
      ptr <= CH_W'(NUM_CH - 1);
    end else if (launch) begin
      bus.write_req <= 1'b1;
      bus.vrf_dst_addr <= slot_addr[sel];
      bus.data_recv <= slot_data[sel];
      bus.write_ch <= sel;
      ptr <= sel;
    end else if (free) begin
      bus.write_req <= 1'b0;
    end
  end
`ifdef WR_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (bus.write_req && !bus.write_gnt && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule
